// File: rtl/game_status_unit.sv
// game_status_unit: status/event side of the game control loop.
// Debounces two pushbuttons into single-cycle press pulses, runs the 4 s timer,
// keeps the lives count and a free-running 8-bit LFSR for launch direction.
// Build option: define GAME_FAST_SIM_EN to shrink the timer threshold to 16 and
// the debounce threshold to 4 (widths unchanged) for fast simulation.

// Per-button synchronizer + two-state debouncer + press pulse generator.
module game_status_deb #(
   parameter int DEB_THR = 1000000,
   parameter int DEB_W   = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);
   typedef enum logic {STABLE_LO = 1'b0, STABLE_HI = 1'b1} deb_state_e;

   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_THR - 1);

   logic [1:0]       sync;
   logic [DEB_W-1:0] cnt;
   deb_state_e       state;
   deb_state_e       state_d;

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b00;
      else        sync <= {sync[0], raw};
   end

   // Accept a level change only after it has held for DEB_THR cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         state <= STABLE_LO;
      end else if (sync[1] != state) begin
         if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= (state == STABLE_LO) ? STABLE_HI : STABLE_LO;
         end else begin
            cnt <= cnt + DEB_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   // Registered rising-edge detect on the stable state: one pulse per press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_d <= STABLE_LO;
         pulse   <= 1'b0;
      end else begin
         state_d <= state;
         pulse   <= (state == STABLE_HI) && (state_d == STABLE_LO);
      end
   end
endmodule

module game_status_unit #(
   parameter int FOUR_SEC_COUNT = 400000000,
   parameter int TIMER_W        = 29,
   parameter int DEB_CYCLES     = 1000000,
   parameter int DEB_W          = 20,
   parameter int LIVES_INIT     = 3,
   parameter int LIVES_W        = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pb1_raw,
   input  logic               pb2_raw,
   input  logic               resettimer,
   input  logic               loadlives,
   input  logic               decrementlives,
   input  logic               loadrandom,
   output logic               pb1,
   output logic               pb2,
   output logic               foursec,
   output logic               nolives,
   output logic [LIVES_W-1:0] lives,
   output logic [7:0]         rand_val
);
`ifdef GAME_FAST_SIM_EN
   localparam int TIMER_THR = 16;
   localparam int DEB_THR   = 4;
`else
   localparam int TIMER_THR = FOUR_SEC_COUNT;
   localparam int DEB_THR   = DEB_CYCLES;
`endif

   localparam int NUM_BTN = 2;
   localparam logic [TIMER_W-1:0] TMR_LAST  = TIMER_W'(TIMER_THR - 1);
   localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_pulse;

   assign btn_raw = {pb2_raw, pb1_raw};
   assign pb1     = btn_pulse[0];
   assign pb2     = btn_pulse[1];

   // One independent debouncer per button.
   generate
      for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
         game_status_deb #(.DEB_THR(DEB_THR), .DEB_W(DEB_W)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[b]),
            .pulse (btn_pulse[b])
         );
      end
   endgenerate

   logic [TIMER_W-1:0] tmr_cnt;

   // Saturating interval timer; foursec latches high on the final count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_cnt <= '0;
         foursec <= 1'b0;
      end else if (resettimer) begin
         tmr_cnt <= '0;
         foursec <= 1'b0;
      end else if (tmr_cnt == TMR_LAST) begin
         foursec <= 1'b1;
      end else begin
         tmr_cnt <= tmr_cnt + TIMER_W'(1);
      end
   end

   logic               dec_d;
   logic               dec_evt;
   logic [LIVES_W-1:0] lives_nxt;

   assign dec_evt = decrementlives & ~dec_d;

   // Next lives value: load wins over decrement, decrement floors at zero.
   always_comb begin
      lives_nxt = lives;
      if (loadlives)                        lives_nxt = LIVES_RST;
      else if (dec_evt && (lives != '0))    lives_nxt = lives - LIVES_W'(1);
   end

   // Lives register, nolives flag updated on the same edge, and edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lives   <= LIVES_RST;
         nolives <= (LIVES_RST == '0);
         dec_d   <= 1'b0;
      end else begin
         lives   <= lives_nxt;
         nolives <= (lives_nxt == '0);
         dec_d   <= decrementlives;
      end
   end

   logic [7:0] lfsr;

   // Free-running Galois LFSR (taps 0xB8); capture pre-step value on loadrandom.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr     <= 8'h01;
         rand_val <= 8'h00;
      end else begin
         lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
         if (loadrandom) rand_val <= lfsr;
      end
   end
endmodule

// File: doc/game_status_unit.md
Name: game_status_unit

Overview:
- Status/event side of the game control loop.
- Consumes the command outputs of the game FSM: resettimer, loadlives, decrementlives, loadrandom.
- Produces the FSM's condition inputs: debounced single-cycle pb1/pb2 pulses, foursec and nolives.
- Also holds the lives count and a pseudo-random value for the datapath (ball launch direction).

Parameters:
- FOUR_SEC_COUNT, 400000000: clock cycles in the 4 s interval (100 MHz).
- TIMER_W, 29: timer counter width.
- DEB_CYCLES, 1000000: stable cycles required to accept a button change (10 ms).
- DEB_W, 20: debounce counter width.
- LIVES_INIT, 3: value loaded by loadlives and by reset.
- LIVES_W, 2: lives counter width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pb1_raw  in  1  raw pushbutton 1, asynchronous to clk.
- pb2_raw  in  1  raw pushbutton 2, asynchronous to clk.
- resettimer  in  1  restart the 4 s timer.
- loadlives  in  1  load lives with LIVES_INIT.
- decrementlives  in  1  remove one life; acts on its rising edge.
- loadrandom  in  1  capture the LFSR into rand_val.
- pb1  out  1  one-cycle pulse per debounced press of button 1.
- pb2  out  1  one-cycle pulse per debounced press of button 2.
- foursec  out  1  level; high once the interval has elapsed.
- nolives  out  1  high when lives == 0.
- lives  out  LIVES_W  current lives count.
- rand_val  out  8  captured random value.

Behaviour:
- Reset (rst_n low, async):
  - pb1=pb2=0, foursec=0, timer=0.
  - lives=LIVES_INIT, nolives=0, rand_val=8'h00, LFSR=8'h01.
  - Synchronizers, debounce stable flags and debounce counters = 0.
  - Timer starts counting on the first edge after release.
- Button path, per button, independent:
  - 2-flop synchronizer feeds a 2-state debouncer (STABLE_LO / STABLE_HI).
  - Counter increments while synced != stable and clears whenever they are equal.
  - On the edge where the counter reaches DEB_CYCLES-1: stable toggles and the counter clears.
  - A STABLE_LO->STABLE_HI transition registers a pulse high for exactly 1 cycle.
  - Latency: pulse asserts DEB_CYCLES+3 cycles after the last raw edge.
  - Release produces no pulse.
  - A bounce shorter than DEB_CYCLES produces no output change.
- Timer:
  - resettimer high at edge k -> count=0 and foursec=0 after edge k.
  - Count increments each cycle and saturates at FOUR_SEC_COUNT-1.
  - foursec is registered; it goes high exactly FOUR_SEC_COUNT edges after the resettimer edge.
  - foursec holds high until the next resettimer.
  - resettimer held high keeps count at 0.
  - resettimer mid-count restarts the full interval.
- Lives:
  - Priority: loadlives > decrement.
  - decrement_evt = decrementlives & ~decrementlives_d; decrementlives_d updates every cycle regardless of loadlives.
  - decrement_evt saturates at 0; no wrap to the maximum value.
  - A level held for many cycles decrements once.
  - nolives is registered and updated on the same edge as lives.
- Random:
  - 8-bit Galois LFSR, free-running every cycle: next = lfsr[0] ? (lfsr>>1)^8'hB8 : lfsr>>1.
  - Never reaches 0.
  - loadrandom (level) high at an edge -> rand_val gets the current LFSR value (pre-step).

Optional Feature:
- Macro: GAME_FAST_SIM_EN.
- Defined: effective timer threshold is 16 and effective debounce threshold is 4, overriding the parameters. Widths are unchanged.
- Undefined: FOUR_SEC_COUNT and DEB_CYCLES are used as given.
- All other behaviour is identical in both builds.
- The test plan values below assume GAME_FAST_SIM_EN is defined.

Test Plan:
- Reset: assert rst_n=0 mid-count with lives=1 -> immediately lives=3, nolives=0, foursec=0, pb1=pb2=0, rand_val=0x00.
- Timer:
  - resettimer pulsed 1 cycle at edge k -> foursec low through edge k+15, high after edge k+16, still high 50 cycles later.
  - Second resettimer at count 10 -> foursec stays low, rises 16 edges after it.
- Lives:
  - decrementlives held high 5 cycles -> lives 3->2 only.
  - Two further 1-cycle pulses -> lives=0, nolives=1; a fourth pulse leaves lives=0.
  - loadlives and a decrementlives rising edge in the same cycle -> lives=3, nolives=0.
- Debounce:
  - pb1_raw toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one pb1 pulse, 1 cycle wide, 7 cycles after the final raw edge; pb2 stays 0.
  - Releasing pb1_raw afterwards -> no pulse.
- Random: loadrandom high on edges 1-4 after reset release -> rand_val sequence 0x01, 0xB8, 0x5C, 0x2E.
- Simultaneous: button press completes on the same edge as resettimer and loadlives -> pb1 pulse, count=0 and lives=3 all take effect; no interference.
